// File: rtl/class_vote_aggregator.sv
// class_vote_aggregator
// Accumulates per-class tree votes over a stream of beats, then scans the
// per-class counters one class per cycle to find the winner (ties resolve to
// the lowest index) and holds the result until it is consumed.
// Optional feature macro: CLASS_VOTE_COUNT_EN adds the res_count output
// carrying the winning vote count.
module class_vote_aggregator #(
  parameter  int N_CLASS   = 6,
  parameter  int MAX_TREES = 15,
  localparam int CNT_W     = $clog2(MAX_TREES + 1),
  localparam int IDX_W     = (N_CLASS > 1) ? $clog2(N_CLASS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vote_valid,
  output logic               vote_ready,
  input  logic [N_CLASS-1:0] vote_hits,
  input  logic               vote_last,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [IDX_W-1:0]   res_class,
  output logic               res_ovf
`ifdef CLASS_VOTE_COUNT_EN
  ,
  output logic [CNT_W-1:0]   res_count
`endif
);

  typedef enum logic [1:0] {
    ACCUM,
    ARGMAX,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q [N_CLASS];
  logic [CNT_W-1:0] cnt_d [N_CLASS];
  logic             ovf_q, ovf_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic [CNT_W-1:0] best_cnt_q, best_cnt_d;
  logic             res_valid_q, res_valid_d;
  logic [IDX_W-1:0] res_class_q, res_class_d;
  logic             res_ovf_q, res_ovf_d;
`ifdef CLASS_VOTE_COUNT_EN
  logic [CNT_W-1:0] res_count_q, res_count_d;
`endif

  logic accept;

  assign vote_ready = (state_q == ACCUM);
  assign accept     = vote_valid && (state_q == ACCUM);
  assign res_valid  = res_valid_q;
  assign res_class  = res_class_q;
  assign res_ovf    = res_ovf_q;
`ifdef CLASS_VOTE_COUNT_EN
  assign res_count  = res_count_q;
`endif

  // Next-state: accumulate votes, sequential argmax scan, result hold/handshake.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    idx_d       = idx_q;
    best_idx_d  = best_idx_q;
    best_cnt_d  = best_cnt_q;
    res_valid_d = res_valid_q;
    res_class_d = res_class_q;
    res_ovf_d   = res_ovf_q;
`ifdef CLASS_VOTE_COUNT_EN
    res_count_d = res_count_q;
`endif
    unique case (state_q)
      ACCUM: begin
        if (accept) begin
          for (int unsigned k = 0; k < N_CLASS; k++) begin
            if (vote_hits[k]) begin
              if (cnt_q[k] == CNT_W'(MAX_TREES)) begin
                ovf_d = 1'b1;
              end else begin
                cnt_d[k] = cnt_q[k] + CNT_W'(1);
              end
            end
          end
          if (vote_last) begin
            state_d = ARGMAX;
            idx_d   = '0;
          end
        end
      end
      ARGMAX: begin
        if (cnt_q[idx_q] > best_cnt_q) begin
          best_idx_d = idx_q;
          best_cnt_d = cnt_q[idx_q];
        end
        // The result registers load from the post-compare best so the final
        // class is included in the same cycle the scan finishes.
        if (idx_q == IDX_W'(N_CLASS - 1)) begin
          state_d     = DONE;
          res_valid_d = 1'b1;
          res_class_d = best_idx_d;
          res_ovf_d   = ovf_q;
`ifdef CLASS_VOTE_COUNT_EN
          res_count_d = best_cnt_d;
`endif
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d     = ACCUM;
          res_valid_d = 1'b0;
          for (int unsigned k = 0; k < N_CLASS; k++) begin
            cnt_d[k] = '0;
          end
          ovf_d      = 1'b0;
          best_idx_d = '0;
          best_cnt_d = '0;
          idx_d      = '0;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial sample or result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      for (int unsigned k = 0; k < N_CLASS; k++) begin
        cnt_q[k] <= '0;
      end
      ovf_q       <= 1'b0;
      idx_q       <= '0;
      best_idx_q  <= '0;
      best_cnt_q  <= '0;
      res_valid_q <= 1'b0;
      res_class_q <= '0;
      res_ovf_q   <= 1'b0;
`ifdef CLASS_VOTE_COUNT_EN
      res_count_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      for (int unsigned k = 0; k < N_CLASS; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
      ovf_q       <= ovf_d;
      idx_q       <= idx_d;
      best_idx_q  <= best_idx_d;
      best_cnt_q  <= best_cnt_d;
      res_valid_q <= res_valid_d;
      res_class_q <= res_class_d;
      res_ovf_q   <= res_ovf_d;
`ifdef CLASS_VOTE_COUNT_EN
      res_count_q <= res_count_d;
`endif
    end
  end

endmodule
